// File: rtl/arith_div.sv
// Sequential 8-bit restoring divider; done pulses 10 cycles after an accepted start (1 for divide-by-zero).
// start is ignored while busy (no queueing); `define DIV_SIGNED_EN enables two's-complement operation via SIGNED.
module arith_div (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       SIGNED,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       busy,
  output logic       done,
  output logic       DIV0,
  output logic       OV
);

  typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  quo_q, rem_q, dvs_q;
  logic        qneg_q, rneg_q, ovf_q;
  logic [7:0]  q_q, r_q;
  logic        busy_q, done_q, div0_q, ov_q;

  logic        sgn_d, ovf_d;
  logic [7:0]  a_mag_d, b_mag_d;
  logic [8:0]  sh_d, trial_d;
  logic        ge_d;

`ifdef DIV_SIGNED_EN
  assign sgn_d = SIGNED;
  assign ovf_d = SIGNED && (A == 8'h80) && (B == 8'hFF);
`else
  logic unused_signed;
  assign unused_signed = SIGNED;
  assign sgn_d = 1'b0;
  assign ovf_d = 1'b0;
`endif

  // |-128| = 8'h80 still reads correctly as an unsigned magnitude
  assign a_mag_d = (sgn_d && A[7]) ? (~A + 8'd1) : A;
  assign b_mag_d = (sgn_d && B[7]) ? (~B + 8'd1) : B;

  assign sh_d    = {rem_q, quo_q[7]};
  assign ge_d    = (sh_d >= {1'b0, dvs_q});
  assign trial_d = sh_d - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      quo_q   <= 8'd0;
      rem_q   <= 8'd0;
      dvs_q   <= 8'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // the done cycle is still busy, so a start there is dropped
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            busy_q <= 1'b1;
            if (B == 8'd0) begin
              q_q     <= 8'hFF;
              r_q     <= A;
              div0_q  <= 1'b1;
              ov_q    <= 1'b0;
              state_q <= DONE;
            end else begin
              quo_q   <= a_mag_d;
              rem_q   <= 8'd0;
              dvs_q   <= b_mag_d;
              qneg_q  <= sgn_d && (A[7] ^ B[7]);
              rneg_q  <= sgn_d && A[7];
              ovf_q   <= ovf_d;
              cnt_q   <= 3'd0;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          quo_q <= {quo_q[6:0], ge_d};
          rem_q <= ge_d ? trial_d[7:0] : sh_d[7:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= FIX;
        end
        FIX: begin
          q_q     <= ovf_q ? 8'h80 : (qneg_q ? (~quo_q + 8'd1) : quo_q);
          r_q     <= ovf_q ? 8'h00 : (rneg_q ? (~rem_q + 8'd1) : rem_q);
          div0_q  <= 1'b0;
          ov_q    <= ovf_q;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign DIV0 = div0_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_arith_div.sv
// Directed bench for arith_div: expected results queued at each accepted start, checked at done.
module tb_arith_div;

  logic       clk = 1'b0;
  logic       rst, start, SIGNED;
  logic [7:0] A, B;
  logic [7:0] Q, R;
  logic       busy, done, DIV0, OV;

  arith_div dut (
    .clk(clk), .rst(rst), .start(start), .SIGNED(SIGNED), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .DIV0(DIV0), .OV(OV)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       d0;
    logic       ov;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start across one edge and queue what it must produce.
  task automatic go(input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [7:0] q, input logic [7:0] r, input logic d0,
                    input logic ov, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.d0 = d0; e.ov = ov; e.lat = lat;
    A = a; B = b; SIGNED = s; start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // n0 = cycles already elapsed since the start edge; poke = try a start in the done cycle.
  task automatic wait_done(input string tag, input int n0, input logic poke);
    int   n;
    exp_t e;
    n = n0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_Q"}, {24'd0, Q}, {24'd0, e.q});
      chk({tag, "_R"}, {24'd0, R}, {24'd0, e.r});
      chk({tag, "_DIV0"}, {31'd0, DIV0}, {31'd0, e.d0});
      chk({tag, "_OV"}, {31'd0, OV}, {31'd0, e.ov});
    end
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    if (poke) begin
      A = 8'd9; B = 8'd3; SIGNED = 1'b0; start = 1'b1;
    end
    tick();
    start = 1'b0;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_fell"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int   seen;
    rst = 1'b1; start = 1'b0; SIGNED = 1'b0; A = 8'd0; B = 8'd0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_Q", {24'd0, Q}, 32'd0);
    chk("reset_R", {24'd0, R}, 32'd0);
    chk("reset_flags", {28'd0, busy, done, DIV0, OV}, 32'd0);

    go(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, 10);
    wait_done("u200_7", 0, 1'b0);

    go(8'd55, 8'd0, 1'b0, 8'hFF, 8'd55, 1'b1, 1'b0, 1);
    wait_done("div0", 0, 1'b0);

`ifdef DIV_SIGNED_EN
    go(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 10);
    wait_done("ovf", 0, 1'b0);
    go(8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 10);
    wait_done("s_m100_7", 0, 1'b0);
    go(8'd100, 8'hF9, 1'b1, 8'hF2, 8'd2, 1'b0, 1'b0, 10);
    wait_done("s_100_m7", 0, 1'b0);
`else
    go(8'h80, 8'hFF, 1'b1, 8'h00, 8'h80, 1'b0, 1'b0, 10);
    wait_done("ovf_unsigned", 0, 1'b0);
    go(8'h9C, 8'd7, 1'b1, 8'd22, 8'd2, 1'b0, 1'b0, 10);
    wait_done("u156_7", 0, 1'b0);
    go(8'd100, 8'hF9, 1'b1, 8'd0, 8'd100, 1'b0, 1'b0, 10);
    wait_done("u100_249", 0, 1'b0);
`endif

    // Second start 3 cycles in must be ignored; a start in the done cycle too.
    go(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 1'b0, 10);
    tick(); tick();
    A = 8'd9; B = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_ignore", 3, 1'b1);
    go(8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0, 1'b0, 10);
    wait_done("restart", 0, 1'b0);

    // Reset lands on the edge of DIV step 5.
    A = 8'd200; B = 8'd7; SIGNED = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_Q", {24'd0, Q}, 32'd0);
    chk("abort_R", {24'd0, R}, 32'd0);
    chk("abort_flags", {28'd0, busy, done, DIV0, OV}, 32'd0);
    seen = 0;
    repeat (12) begin
      tick();
      if (done) seen = 1;
    end
    chk("abort_no_done", seen, 0);

    go(8'd250, 8'd16, 1'b0, 8'd15, 8'd10, 1'b0, 1'b0, 10);
    wait_done("after_abort", 0, 1'b0);

    // Reset beats a simultaneous start.
    A = 8'd3; B = 8'd1; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_wins_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("rst_wins_idle", {30'd0, busy, done}, 32'd0);

    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
